// File: rtl/segment7_scanner_pkg.sv
// Shared types, constants and the hex-to-7-segment table for the multiplexed display scanner.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package segment7_scanner_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;
    typedef logic [3:0] guard_t;

    localparam seg_t SEG_OFF = 7'h7F;

    function automatic seg_t hex_to_seg(input nibble_t n);
        seg_t s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/segment7_scanner_decode.sv
// Combinational nibble-to-segment decoder with a blank override; usable outside the scanner.
module seg7_decode
    import segment7_scanner_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_OFF : hex_to_seg(nibble);

endmodule

// File: rtl/segment7_scanner.sv
// Time-multiplexed hex display scanner: edge-detected scan advance, anode guard gap,
// and double-buffered display data that only swaps in at a frame boundary.
module segment7_scanner
    import segment7_scanner_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int GUARD  = 2,
    parameter int LZS    = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SCAN_IN,
    input  logic [4*DIGITS-1:0]   DATA,
    input  logic [DIGITS-1:0]     DP,
    input  logic [DIGITS-1:0]     BLANK,
    input  logic                  LOAD,
    output logic [6:0]            SEG,
    output logic                  DP_OUT,
    output logic [DIGITS-1:0]     AN,
    output logic                  FRAME_DONE
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic                scan_q_reg,     scan_q_next;
    logic                scanning_reg,   scanning_next;
    logic [IDX_W-1:0]    idx_reg,        idx_next;
    guard_t              guard_cnt_reg,  guard_cnt_next;
    logic                pend_reg,       pend_next;
    logic [4*DIGITS-1:0] pend_data_reg,  pend_data_next;
    logic [DIGITS-1:0]   pend_dp_reg,    pend_dp_next;
    logic [DIGITS-1:0]   pend_blank_reg, pend_blank_next;
    logic [4*DIGITS-1:0] act_data_reg,   act_data_next;
    logic [DIGITS-1:0]   act_dp_reg,     act_dp_next;
    logic [DIGITS-1:0]   act_blank_reg,  act_blank_next;
    seg_t                seg_reg,        seg_next;
    logic                dp_out_reg,     dp_out_next;
    logic [DIGITS-1:0]   an_reg,         an_next;
    logic                frame_done_reg, frame_done_next;

    logic                tick;
    logic                boundary;
    logic                zero_run;
    logic [DIGITS-1:0]   upper_zero;
    logic [DIGITS-1:0]   digit_dark;
    seg_t                digit_seg [DIGITS];
    seg_t                sel_seg;
    logic                sel_dp;

    assign tick     = SCAN_IN & ~scan_q_reg;
    assign boundary = tick & (idx_reg == IDX_LAST);

    // upper_zero[i]: digit i and every digit above it hold zero
    always_comb begin
        zero_run   = 1'b1;
        upper_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run & (act_data_reg[4*i +: 4] == 4'h0);
            upper_zero[i] = zero_run;
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_dark[gi] = act_blank_reg[gi]
                                  | ((LZS != 0) && (gi != 0) && upper_zero[gi]);
            seg7_decode u_decode (
                .nibble (act_data_reg[4*gi +: 4]),
                .blank  (digit_dark[gi]),
                .seg    (digit_seg[gi])
            );
        end
    endgenerate

    // A zero-suppressed digit keeps its decimal point; a forced blank kills it
    always_comb begin
        sel_seg = SEG_OFF;
        sel_dp  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                sel_seg = digit_seg[i];
                sel_dp  = act_dp_reg[i] & ~act_blank_reg[i];
            end
        end
    end

    always_comb begin
        scan_q_next     = SCAN_IN;
        scanning_next   = scanning_reg;
        idx_next        = idx_reg;
        guard_cnt_next  = guard_cnt_reg;
        pend_next       = pend_reg;
        pend_data_next  = pend_data_reg;
        pend_dp_next    = pend_dp_reg;
        pend_blank_next = pend_blank_reg;
        act_data_next   = act_data_reg;
        act_dp_next     = act_dp_reg;
        act_blank_next  = act_blank_reg;
        seg_next        = seg_reg;
        dp_out_next     = dp_out_reg;
        an_next         = an_reg;
        frame_done_next = 1'b0;

        if (tick) begin
            idx_next       = boundary ? '0 : idx_reg + IDX_W'(1);
            an_next        = '1;
            guard_cnt_next = guard_t'(GUARD);
            scanning_next  = 1'b1;
            if (boundary && pend_reg) begin
                act_data_next   = pend_data_reg;
                act_dp_next     = pend_dp_reg;
                act_blank_next  = pend_blank_reg;
                pend_next       = 1'b0;
                frame_done_next = 1'b1;
            end
        end else if (guard_cnt_reg != '0) begin
            an_next        = '1;
            guard_cnt_next = guard_cnt_reg - guard_t'(1);
        end else if (scanning_reg) begin
            an_next     = ~(DIGITS'(1) << idx_reg);
            seg_next    = sel_seg;
            dp_out_next = ~sel_dp;
        end

        // A LOAD coinciding with a boundary lands after the swap, so it waits a frame
        if (LOAD) begin
            pend_next       = 1'b1;
            pend_data_next  = DATA;
            pend_dp_next    = DP;
            pend_blank_next = BLANK;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            scan_q_reg     <= 1'b0;
            scanning_reg   <= 1'b0;
            idx_reg        <= IDX_LAST;
            guard_cnt_reg  <= '0;
            pend_reg       <= 1'b0;
            pend_data_reg  <= '0;
            pend_dp_reg    <= '0;
            pend_blank_reg <= '0;
            act_data_reg   <= '0;
            act_dp_reg     <= '0;
            act_blank_reg  <= '0;
            seg_reg        <= SEG_OFF;
            dp_out_reg     <= 1'b1;
            an_reg         <= '1;
            frame_done_reg <= 1'b0;
        end else begin
            scan_q_reg     <= scan_q_next;
            scanning_reg   <= scanning_next;
            idx_reg        <= idx_next;
            guard_cnt_reg  <= guard_cnt_next;
            pend_reg       <= pend_next;
            pend_data_reg  <= pend_data_next;
            pend_dp_reg    <= pend_dp_next;
            pend_blank_reg <= pend_blank_next;
            act_data_reg   <= act_data_next;
            act_dp_reg     <= act_dp_next;
            act_blank_reg  <= act_blank_next;
            seg_reg        <= seg_next;
            dp_out_reg     <= dp_out_next;
            an_reg         <= an_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign SEG        = seg_reg;
    assign DP_OUT     = dp_out_reg;
    assign AN         = an_reg;
    assign FRAME_DONE = frame_done_reg;

endmodule
